multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//  Sequences the shared multi-cycle multiply/divide unit for the pipelined processor's X stage.
//  Decodes the X-stage instruction and, for mul/div, latches operands and pulses the unit start.
//  Holds the pipeline stall until the unit reports ready, then presents one registered writeback.
//  Maps unit exceptions and timeouts to an rstatus write to $r30.
// PARAMETERS
//  TIMEOUT_CYC   64   max WAIT cycles before forced exception completion
//  CNT_W         7    width of WAIT-cycle counter (>= clog2(TIMEOUT_CYC+1))
// PORTS
//  clock          in   1   system clock, rising edge
//  reset_n        in   1   asynchronous active-low reset
//  x_instr        in   32  X-stage instruction: opcode[31:27], rd[26:22], ALUop[6:2]
//  x_valid        in   1   x_instr holds a real (non-bubble) instruction
//  x_opA          in   32  bypassed rs operand
//  x_opB          in   32  bypassed rt operand
//  flush          in   1   branch/jump squash of X stage
//  unit_ready     in   1   unit result/exception valid (one-cycle pulse)
//  unit_result    in   32  unit product/quotient
//  unit_exception in   1   unit overflow/div-by-zero, qualified by unit_ready
//  ctrl_mult      out  1   one-cycle multiply start pulse
//  ctrl_div       out  1   one-cycle divide start pulse
//  md_opA,md_opB  out  32  latched operands, stable from ISSUE through WAIT
//  stall          out  1   freeze F/D/X, insert bubble into M
//  wb_valid       out  1   one-cycle writeback strobe
//  wb_rd          out  5   writeback register
//  wb_data        out  32  writeback value
//  busy           out  1   state != IDLE
// BEHAVIOUR
//  Decode: is_md = x_valid & opcode==5'b00000 & ALUop in {00110 mul, 00111 div}; any other ALUop is not md.
//  States: IDLE, ISSUE, WAIT, DONE. Reset: IDLE; all outputs 0; latches 0; counter 0.
//  IDLE: stall = is_md & ~flush (combinational). If is_md & ~flush: latch opA/opB, rd, op -> ISSUE.
//  ISSUE: exactly one of ctrl_mult/ctrl_div = 1; stall = 1; counter cleared -> WAIT.
//  WAIT: stall = 1; counter++ per cycle.
//   - unit_ready: register result/exception -> DONE.
//   - counter == TIMEOUT_CYC without unit_ready: force exception -> DONE.
//  DONE: stall = 0, wb_valid = 1 for exactly this cycle -> IDLE. Pipeline advances on this edge,
//   so the completed instruction is never re-detected.
//  Writeback: no exception -> wb_rd = latched rd, wb_data = unit_result.
//   Exception or timeout -> wb_rd = 5'd30, wb_data = 32'd4 (mul) / 32'd5 (div).
//  Latency (unit ready k cycles after start pulse): detect T0, ISSUE T1, wb_valid T1+k+1.
//  flush in ISSUE/WAIT/DONE: -> IDLE next edge; no wb_valid; late unit_ready ignored in IDLE.
//   A subsequent start pulse restarts the unit.
//  flush in IDLE with is_md: no transition; stall = 0.
//  unit_ready outside WAIT: ignored. unit_ready and timeout in the same cycle: unit result wins.
//  Back-to-back md: DONE -> IDLE, next md detected in IDLE; one idle-free gap, no overlap.
//  reset_n low in any state: immediate IDLE, outputs 0; no pulse or writeback leaks.
// STRUCTURE
//  Shared defines header proc_defs.vh:
//   - OPC_RTYPE, ALU_MUL, ALU_DIV
//   - RSTATUS_REG (30), RSTATUS_MUL (4), RSTATUS_DIV (5)
//   - field bit positions, FSM state encodings
//  One sub-module: md_wait_counter (CNT_W up-counter with clear, enable, terminal flag at TIMEOUT_CYC).
//  FSM, decode and output registers live in the top.
// TESTING
//  1 mul r3=7*6, rd=3, unit_ready 32 cyc after ctrl_mult -> one ctrl_mult pulse;
//    stall high 34 cycles; wb_valid, wb_rd=3, wb_data=42.
//  2 div r4=10/0, unit_ready+unit_exception -> wb_rd=30, wb_data=5; ctrl_div seen once, ctrl_mult never.
//  3 mul with unit_ready never asserted -> DONE after TIMEOUT_CYC WAIT cycles; wb_rd=30, wb_data=4; stall drops.
//  4 flush during WAIT cycle 10, then unit_ready -> no wb_valid; busy=0; next mul restarts with new pulse.
//  5 back-to-back mul then div, ready at 5 cycles each -> two wb_valid strobes, correct rd/data, no duplicates.
//  6 reset_n low mid-WAIT, plus non-md R-type (ALUop 00000) and bubble (x_valid=0) -> IDLE, all outputs 0; no stall.

Source files
------------

// File: rtl/multdiv_sequencer_pkg.sv
// Shared decode constants, writeback codes and FSM encodings for the mul/div sequencer.
package multdiv_sequencer_pkg;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    localparam logic [4:0]  RSTATUS_REG = 5'd30;
    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 27;
    localparam int unsigned RD_MSB  = 26;
    localparam int unsigned RD_LSB  = 22;
    localparam int unsigned ALU_MSB = 6;
    localparam int unsigned ALU_LSB = 2;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    function automatic logic [31:0] rstatus_code(input logic is_div);
        return is_div ? RSTATUS_DIV : RSTATUS_MUL;
    endfunction

endpackage

// File: rtl/md_wait_counter.sv
// Counts WAIT cycles; terminal_o flags the cycle in which the count reaches TIMEOUT_CYC.
module md_wait_counter #(
    parameter int unsigned CNT_W       = 7,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic terminal_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Fires during the TIMEOUT_CYC-th enabled cycle after a clear.
    assign terminal_o = en_i & ~clr_i & (cnt_d == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// X-stage sequencer for the shared multi-cycle mul/div unit: issue, stall, timeout and writeback.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] x_instr,
    input  logic        x_valid,
    input  logic [31:0] x_opA,
    input  logic [31:0] x_opB,
    input  logic        flush,
    input  logic        unit_ready,
    input  logic [31:0] unit_result,
    input  logic        unit_exception,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    logic [1:0]  state_q, state_d;
    logic        op_div_q, op_div_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        cnt_clr, cnt_en, cnt_term;

    logic [4:0] opcode, alu_op;
    logic       is_md;
    logic       unused_instr_bits;

    assign opcode = x_instr[OPC_MSB:OPC_LSB];
    assign alu_op = x_instr[ALU_MSB:ALU_LSB];
    assign is_md  = x_valid & (opcode == OPC_RTYPE) & ((alu_op == ALU_MUL) | (alu_op == ALU_DIV));
    assign unused_instr_bits = ^{x_instr[RD_LSB-1:ALU_MSB+1], x_instr[ALU_LSB-1:0]};

    md_wait_counter #(
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wait_counter (
        .clk_i     (clock),
        .rst_ni    (reset_n),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .terminal_o(cnt_term)
    );

    always_comb begin
        state_d   = state_q;
        op_div_d  = op_div_q;
        rd_d      = rd_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_md && !flush) begin
                    state_d  = StIssue;
                    op_div_d = (alu_op == ALU_DIV);
                    rd_d     = x_instr[RD_MSB:RD_LSB];
                    opa_d    = x_opA;
                    opb_d    = x_opB;
                end
            end
            StIssue: begin
                cnt_clr = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                cnt_en = 1'b1;
                // A real unit response beats a timeout landing in the same cycle.
                if (unit_ready) begin
                    wb_rd_d   = unit_exception ? RSTATUS_REG : rd_q;
                    wb_data_d = unit_exception ? rstatus_code(op_div_q) : unit_result;
                    state_d   = StDone;
                end else if (cnt_term) begin
                    wb_rd_d   = RSTATUS_REG;
                    wb_data_d = rstatus_code(op_div_q);
                    state_d   = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush && (state_q != StIdle)) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            op_div_q  <= 1'b0;
            rd_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            op_div_q  <= op_div_d;
            rd_q      <= rd_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign ctrl_mult = (state_q == StIssue) & ~op_div_q;
    assign ctrl_div  = (state_q == StIssue) & op_div_q;
    assign md_opA    = opa_q;
    assign md_opB    = opb_q;
    assign stall     = (state_q == StIdle) ? (is_md & ~flush)
                                           : ((state_q == StIssue) | (state_q == StWait));
    assign wb_valid  = (state_q == StDone) & ~flush;
    assign wb_rd     = wb_valid ? wb_rd_q : '0;
    assign wb_data   = wb_valid ? wb_data_q : '0;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: vector table with scoreboarded writebacks plus flush/reset sequences.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] x_instr = '0;
    logic        x_valid = 1'b0;
    logic [31:0] x_opA = '0;
    logic [31:0] x_opB = '0;
    logic        flush = 1'b0;
    logic        unit_ready = 1'b0;
    logic [31:0] unit_result = '0;
    logic        unit_exception = 1'b0;
    logic        ctrl_mult, ctrl_div, stall, wb_valid, busy;
    logic [31:0] md_opA, md_opB, wb_data;
    logic [4:0]  wb_rd;

    always #5 clock = ~clock;

    multdiv_sequencer #(
        .TIMEOUT_CYC(64),
        .CNT_W      (7)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .x_instr       (x_instr),
        .x_valid       (x_valid),
        .x_opA         (x_opA),
        .x_opB         (x_opB),
        .flush         (flush),
        .unit_ready    (unit_ready),
        .unit_result   (unit_result),
        .unit_exception(unit_exception),
        .ctrl_mult     (ctrl_mult),
        .ctrl_div      (ctrl_div),
        .md_opA        (md_opA),
        .md_opB        (md_opB),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .busy          (busy)
    );

    typedef struct {
        bit          is_div;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        int          k;          // unit_ready k cycles after start pulse; 0 = never
        bit          exc;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        int          exp_stall;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   checks = 0, failures = 0;
    int   n_mul = 0, n_div = 0, n_stall = 0, n_wb = 0, wb_expected = 0;

    function automatic logic [31:0] mk_instr(input logic [4:0] opc, input logic [4:0] rd,
                                             input logic [4:0] alu);
        return {opc, rd, 15'd0, alu, 2'b00};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One clock: observe outputs on the falling edge, return just after the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (ctrl_mult) n_mul++;
        if (ctrl_div) n_div++;
        if (stall) n_stall++;
        if (ctrl_mult && ctrl_div) begin
            checks++;
            failures++;
            $display("FAIL both_pulses actual=11 required=one-hot");
        end
        if (wb_valid) begin
            n_wb++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected actual rd=%0d data=0x%0h required=no writeback",
                         wb_rd, wb_data);
            end else begin
                e = sb.pop_front();
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_data", wb_data, e.data);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic wait_pulse(output bit ok);
        int base = n_mul + n_div;
        ok = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (n_mul + n_div != base) begin
                ok = 1'b1;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL start_pulse_timeout actual=none required=pulse within 6 cycles");
    endtask

    task automatic wait_wb(input int budget);
        int base = n_wb;
        for (int i = 0; i < budget; i++) begin
            if (n_wb != base) return;
            tick();
        end
        if (n_wb == base) begin
            checks++;
            failures++;
            $display("FAIL wb_timeout actual=none required=wb_valid within %0d cycles", budget);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int m0 = n_mul;
        int d0 = n_div;
        bit ok;
        sb.push_back('{v.exp_rd, v.exp_data});
        wb_expected++;
        n_stall = 0;
        x_instr = mk_instr(5'd0, v.rd, v.is_div ? 5'b00111 : 5'b00110);
        x_opA = v.a;
        x_opB = v.b;
        x_valid = 1'b1;
        wait_pulse(ok);
        if (ok) begin
            chk("md_opA", md_opA, v.a);
            chk("md_opB", md_opB, v.b);
            if (v.k > 0) begin
                repeat (v.k - 1) tick();
                unit_ready = 1'b1;
                unit_exception = v.exc;
                if (v.is_div) unit_result = (v.b == 0) ? 32'hFFFF_FFFF : v.a / v.b;
                else unit_result = v.a * v.b;
                tick();
                unit_ready = 1'b0;
                unit_exception = 1'b0;
            end
        end
        wait_wb(150);
        x_valid = 1'b0;
        chk("stall_cycles", 32'(n_stall), 32'(v.exp_stall));
        chk("mul_pulses", 32'(n_mul - m0), v.is_div ? 32'd0 : 32'd1);
        chk("div_pulses", 32'(n_div - d0), v.is_div ? 32'd1 : 32'd0);
    endtask

    initial begin
        vec_t extra;
        bit   ok;
        int   wb0, m0, st0;

        vecs[0] = '{0, 5'd3, 32'd7,       32'd6,       32, 0, 5'd3,  32'd42,   34};
        vecs[1] = '{1, 5'd4, 32'd10,      32'd0,       3,  1, 5'd30, 32'd5,    5};
        vecs[2] = '{0, 5'd9, 32'd5,       32'd5,       0,  0, 5'd30, 32'd4,    66};
        vecs[3] = '{0, 5'd5, 32'd1000,    32'd3,       5,  0, 5'd5,  32'd3000, 7};
        vecs[4] = '{1, 5'd6, 32'd100,     32'd7,       5,  0, 5'd6,  32'd14,   7};
        vecs[5] = '{0, 5'd7, 32'd3,       32'd11,      64, 0, 5'd7,  32'd33,   66};
        vecs[6] = '{0, 5'd8, 32'h1_0000,  32'h1_0000,  1,  1, 5'd30, 32'd4,    3};

        // Reset state
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pulses", 32'({ctrl_mult, ctrl_div}), 32'd0);
        chk("rst_wb", 32'({wb_valid, wb_rd}), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_md_opA", md_opA, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Flush in WAIT cycle 10, then a late unit_ready that must be ignored.
        wb0 = n_wb;
        m0 = n_mul;
        x_instr = mk_instr(5'd0, 5'd10, 5'b00110);
        x_opA = 32'd2;
        x_opB = 32'd3;
        x_valid = 1'b1;
        wait_pulse(ok);
        repeat (9) tick();
        chk("wait_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        x_valid = 1'b0;
        tick();
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        unit_ready = 1'b1;
        unit_result = 32'd6;
        tick();
        unit_ready = 1'b0;
        repeat (3) tick();
        chk("flush_no_wb", 32'(n_wb - wb0), 32'd0);
        chk("flush_idle", 32'(busy), 32'd0);
        chk("flush_one_pulse", 32'(n_mul - m0), 32'd1);
        extra = '{0, 5'd12, 32'd9, 32'd9, 2, 0, 5'd12, 32'd81, 4};
        run_vec(extra);

        // Flush in IDLE alongside an md instruction: no stall, no issue.
        m0 = n_mul;
        x_instr = mk_instr(5'd0, 5'd13, 5'b00110);
        x_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("idle_flush_stall", 32'(stall), 32'd0);
        tick();
        tick();
        chk("idle_flush_busy", 32'(busy), 32'd0);
        chk("idle_flush_pulse", 32'(n_mul - m0), 32'd0);
        flush = 1'b0;
        x_valid = 1'b0;

        // Reset mid-WAIT.
        wb0 = n_wb;
        x_instr = mk_instr(5'd0, 5'd11, 5'b00111);
        x_opA = 32'd50;
        x_opB = 32'd5;
        x_valid = 1'b1;
        wait_pulse(ok);
        repeat (5) tick();
        #2;
        reset_n = 1'b0;
        x_valid = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_pulses", 32'({ctrl_mult, ctrl_div, wb_valid}), 32'd0);
        chk("midrst_md_opA", md_opA, 32'd0);
        chk("midrst_md_opB", md_opB, 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        chk("midrst_no_wb", 32'(n_wb - wb0), 32'd0);

        // Non-md R-type and bubbles never stall.
        n_stall = 0;
        m0 = n_mul + n_div;
        x_instr = mk_instr(5'd0, 5'd14, 5'b00000);
        x_valid = 1'b1;
        repeat (3) tick();
        x_instr = mk_instr(5'd1, 5'd14, 5'b00110);
        repeat (3) tick();
        x_instr = mk_instr(5'd0, 5'd14, 5'b00110);
        x_valid = 1'b0;
        repeat (3) tick();
        chk("nonmd_stall", 32'(n_stall), 32'd0);
        chk("nonmd_busy", 32'(busy), 32'd0);
        chk("nonmd_pulses", 32'(n_mul + n_div - m0), 32'd0);

        st0 = n_wb;
        repeat (4) tick();
        chk("wb_total", 32'(st0), 32'(wb_expected));
        chk("no_extra_wb", 32'(n_wb - st0), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
